// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct constants, ALU control codes and datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXE    = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_EXC    = 3'b101
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // PC source select
    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_EXC = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // True for the supported non-R-type opcodes
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)  || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags whether
// the funct belongs to the supported set.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_ctrl,
    output logic       o_legal
);

    // Combinational funct lookup; unknown functs report illegal with ADD
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXE/MEM/WB sequencer with a
// memory ready handshake, wait-timeout counter and ALU-control decode.
// Optional exception state for illegal instructions: define MIPS_CTRL_EXC_EN.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter int WAIT_MAX      = 15,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic [1:0]            pc_src,
    output logic                  ir_we,
    output logic                  iord,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic                  reg_dst,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mem_to_reg,
    output logic                  rwe,
    output logic [2:0]            state_o,
    output logic                  timeout,
    output logic                  illegal
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [CNT_W-1:0] r_wait_cnt;

    logic       w_ready;
    logic       w_waiting;
    logic       w_timeout;
    logic [5:0] w_funct_sel;
    logic [3:0] w_alu_r;
    logic       w_funct_legal;
    logic       w_dec_legal;
    logic [3:0] w_alu;
    logic       w_illegal;

    assign w_ready   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !w_ready;
    assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(WAIT_MAX - 1));

    // In DECODE the IR is fresh and the latches are not yet loaded, so the
    // decoder looks at the live funct; afterwards it uses the latched copy.
    assign w_funct_sel = (r_state == ST_DECODE) ? funct : r_funct;

    mips_alu_dec u_alu_dec (
        .i_funct    (w_funct_sel),
        .o_alu_ctrl (w_alu_r),
        .o_legal    (w_funct_legal)
    );

    assign w_dec_legal = (opcode == OP_RTYPE) ? w_funct_legal : is_known_op(opcode);

    assign alu_ctrl = ALU_CTRL_W'(w_alu);
    assign state_o  = r_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_next;
    end

    // Capture the instruction fields while in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= opcode;
            r_funct  <= funct;
        end
    end

    // Memory wait counter; wraps to zero on the timeout cycle and keeps waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_wait_cnt <= '0;
        else if (w_timeout) r_wait_cnt <= '0;
        else if (w_waiting) r_wait_cnt <= r_wait_cnt + 1'b1;
        else                r_wait_cnt <= '0;
    end

    // Next-state and datapath strobes; everything forced low while in reset
    always_comb begin
        w_next     = r_state;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        w_alu      = ALU_AND;
        mem_to_reg = 1'b0;
        rwe        = 1'b0;
        w_illegal  = 1'b0;
        timeout    = w_timeout;

        case (r_state)
            ST_FETCH: begin
                mem_re = 1'b1;
                if (w_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    pc_src    = PCSRC_ALU;
                    alu_src_b = SRCB_FOUR;
                    w_alu     = ALU_ADD;
                    w_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                w_alu     = ALU_ADD;
                if (!w_dec_legal) begin
`ifdef MIPS_CTRL_EXC_EN
                    w_next = ST_EXC;
`else
                    w_next = ST_FETCH;
`endif
                end else if (opcode == OP_J) begin
                    pc_we  = 1'b1;
                    pc_src = PCSRC_JMP;
                    w_next = ST_FETCH;
                end else begin
                    w_next = ST_EXE;
                end
            end
            ST_EXE: begin
                alu_src_a = 1'b1;
                case (r_opcode)
                    OP_RTYPE: begin
                        w_alu  = w_alu_r;
                        w_next = ST_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b = SRCB_IMM;
                        w_alu     = ALU_ADD;
                        w_next    = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = SRCB_IMM;
                        w_alu     = ALU_ADD;
                        w_next    = ST_MEM;
                    end
                    OP_BEQ: begin
                        w_alu  = ALU_SUB;
                        pc_we  = zero;
                        pc_src = PCSRC_BR;
                        w_next = ST_FETCH;
                    end
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                iord = 1'b1;
                if (r_opcode == OP_LW) begin
                    mem_re = 1'b1;
                    if (w_ready) w_next = ST_WB;
                end else begin
                    mem_we = 1'b1;
                    if (w_ready) w_next = ST_FETCH;
                end
            end
            ST_WB: begin
                rwe        = 1'b1;
                reg_dst    = (r_opcode == OP_RTYPE);
                mem_to_reg = (r_opcode == OP_LW);
                w_next     = ST_FETCH;
            end
`ifdef MIPS_CTRL_EXC_EN
            ST_EXC: begin
                pc_we     = 1'b1;
                pc_src    = PCSRC_EXC;
                w_illegal = 1'b1;
                w_next    = ST_FETCH;
            end
`endif
            default: w_next = ST_FETCH;
        endcase

        if (!rst_n) begin
            pc_we      = 1'b0;
            pc_src     = 2'b00;
            ir_we      = 1'b0;
            iord       = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            reg_dst    = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            w_alu      = 4'b0000;
            mem_to_reg = 1'b0;
            rwe        = 1'b0;
            w_illegal  = 1'b0;
            timeout    = 1'b0;
        end
    end

`ifdef MIPS_CTRL_EXC_EN
    assign illegal = w_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule
